div_seq: RTL and testbench
==========================

# div_seq

Parametrised sequential restoring divider for the processor's multdiv unit. It replaces the fixed 32-bit free-running divider with an explicit start/ready handshake, signed and unsigned modes, a remainder output, and a deterministic divide-by-zero path. The pipeline's multdiv stall logic drives it: issue `ctrl_DIV`, stall while `busy`, and capture on `data_resultRDY`.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width; must be ≥ 4.
- `clock`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `ctrl_DIV`  in  1  start pulse; sampled only when not busy.
- `ctrl_signed`  in  1  1 selects two's-complement operands; sampled with `ctrl_DIV`.
- `data_operandA`  in  WIDTH  dividend; sampled with `ctrl_DIV`.
- `data_operandB`  in  WIDTH  divisor; sampled with `ctrl_DIV`.
- `data_result`  out  WIDTH  quotient; registered, held until the next accepted start.
- `data_remainder`  out  WIDTH  remainder; registered, held like `data_result`.
- `data_exception`  out  1  divide-by-zero flag for the last operation; held like `data_result`.
- `data_resultRDY`  out  1  one-cycle pulse when the result is valid.
- `busy`  out  1  high while an operation is in flight.

## Operation
- FSM states: IDLE, RUN, FIX, DONE.
- **IDLE / DONE, `ctrl_DIV`=1:**
  - Latch the operands and the mode.
  - In signed mode, take magnitudes and record `negQ = signA ^ signB` and `negR = signA`.
  - If B==0, go to DONE. Otherwise clear the partial remainder R, load Q with |A|, clear the step counter, and go to RUN.
- **IDLE / DONE, `ctrl_DIV`=0:** DONE goes to IDLE; IDLE stays in IDLE.
- **RUN, one restoring step per cycle:**
  - Shift {R,Q} left by 1.
  - Compute T = R − |B| at WIDTH+1 bits.
  - If T ≥ 0: R ← T and Q[0] ← 1. Otherwise R is kept and Q[0] ← 0.
  - After WIDTH steps (counter reaches WIDTH−1), go to FIX.
- **FIX:**
  - Quotient = negQ ? −Q : Q.
  - Remainder = negR ? −R : R.
  - Load both output registers, set exception = 0, and go to DONE.
- **Divide by zero (IDLE/DONE → DONE directly):** quotient = 0, remainder = A as given, exception = 1.
- **Signed overflow (MIN / −1):** quotient = MIN, remainder = 0, exception = 0. This falls out of unsigned magnitude arithmetic and needs no special case.
- **Truncating semantics:** quotient rounds toward zero; a nonzero remainder has the sign of the dividend.
- **Unsigned mode:** operands are used as-is and both sign flags are 0.
- **`ctrl_DIV` during RUN/FIX:** ignored; the in-flight operation is unaffected and no queueing occurs.
- **Reset, including mid-operation:** forces IDLE. `data_result`, `data_remainder`, `data_exception`, `data_resultRDY` and `busy` all become 0, and the counter clears.

## Timing
- Cycle k: `ctrl_DIV`=1 while in IDLE/DONE, operands valid.
- Normal path, B≠0:
  - `busy`=1 in cycles k+1 … k+WIDTH+1 (RUN for WIDTH cycles, then FIX).
  - `data_resultRDY`=1 only in cycle k+WIDTH+2. Total latency is WIDTH+2, i.e. 34 for WIDTH=32.
- Divide by zero: `busy` stays 0 and `data_resultRDY`=1 in cycle k+1.
- Back-to-back: a start presented in the DONE cycle is accepted. The RDY pulse still occurs, and the new operation begins with no idle bubble.
- Outputs change only on the cycle entering DONE, or on reset.
- The operand inputs are don't-care outside start cycles.

## Structure
- Package `div_pkg` holds:
  - the state enum (IDLE, RUN, FIX, DONE);
  - the `clog2`-based counter-width function.
- Sub-module `div_step #(WIDTH)`: purely combinational single restoring step, taking {R,Q} and |B} and returning the next {R,Q}.
  - Instantiated once in `div_seq`.
- `div_seq` itself contains the FSM, the counter, sign handling and the output registers.

## Test plan
- **Unsigned, WIDTH=32, 100 / 7:** q=14, r=2, exception=0; RDY exactly at k+34; `busy` high for 33 cycles.
- **Signed:**
  - −100 / 7 → q=0xFFFFFFF2, r=0xFFFFFFFE.
  - 100 / −7 → q=0xFFFFFFF2, r=2.
- **Divide by zero:** 5 / 0 in signed and unsigned modes → q=0, r=5, exception=1; RDY at k+1; `busy` never high.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0, exception=0.
- **Handshake:**
  - A second `ctrl_DIV` at k+5 is ignored and the first result is unchanged.
  - A start in the DONE cycle is accepted, with the next RDY WIDTH+2 cycles later.
  - `reset` at k+10 → all outputs 0, no RDY pulse.
- **WIDTH=8, unsigned 255 / 16:** q=15, r=15, RDY at k+10.
- **WIDTH=8, signed −128 / 3:** q=0xD6 (−42), r=0xFE (−2).

Source files
------------

// File: rtl/div_pkg.sv
// Shared types for the sequential divider: FSM state encoding and counter sizing.
// Latency and backpressure are properties of div_seq; this package holds no logic.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } divState_t;

   // Step counter only needs to reach w-1, so clog2(w) bits suffice.
   function automatic int cntWidth(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {R,Q} left, trial-subtract |B|, set the quotient bit.
// Purely combinational, zero latency; no handshake, so no backpressure.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] remIn,
   input  logic [WIDTH-1:0] quoIn,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] remOut,
   output logic [WIDTH-1:0] quoOut
);

   logic [WIDTH:0] remShift;
   logic [WIDTH:0] trial;
   logic           fits;

   // R < |B| holds between steps, so the shifted remainder never exceeds
   // 2|B|-1 and the top bit of the WIDTH+1 difference is a clean borrow flag.
   always_comb begin
      remShift = {remIn, quoIn[WIDTH-1]};
      trial    = remShift - {1'b0, divisor};
      fits     = ~trial[WIDTH];
      remOut   = fits ? trial[WIDTH-1:0] : remShift[WIDTH-1:0];
      quoOut   = {quoIn[WIDTH-2:0], fits};
   end

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider (signed/unsigned) with quotient, remainder and div-by-zero flag.
// Latency WIDTH+2 (1 for divide-by-zero); starts while busy are ignored, not queued.
module div_seq
   import div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_DIV,
   input  logic             ctrl_signed,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic [WIDTH-1:0] data_remainder,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int CW = cntWidth(WIDTH);

   divState_t        state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] remReg;
   logic [WIDTH-1:0] quoReg;
   logic [WIDTH-1:0] divMag;
   logic             negQ;
   logic             negR;

   logic             signA;
   logic             signB;
   logic [WIDTH-1:0] magA;
   logic [WIDTH-1:0] magB;
   logic [WIDTH-1:0] remNext;
   logic [WIDTH-1:0] quoNext;

   // Magnitude of MIN is 2^(WIDTH-1) as an unsigned value, which is what the
   // datapath needs, so MIN / -1 needs no special handling.
   always_comb begin
      signA = ctrl_signed & data_operandA[WIDTH-1];
      signB = ctrl_signed & data_operandB[WIDTH-1];
      magA  = signA ? (~data_operandA + 1'b1) : data_operandA;
      magB  = signB ? (~data_operandB + 1'b1) : data_operandB;
   end

   div_step #(
      .WIDTH(WIDTH)
   ) uStep (
      .remIn  (remReg),
      .quoIn  (quoReg),
      .divisor(divMag),
      .remOut (remNext),
      .quoOut (quoNext)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         remReg         <= '0;
         quoReg         <= '0;
         divMag         <= '0;
         negQ           <= 1'b0;
         negR           <= 1'b0;
         data_result    <= '0;
         data_remainder <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
         busy           <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (ctrl_DIV) begin
                  negQ   <= signA ^ signB;
                  negR   <= signA;
                  divMag <= magB;
                  if (data_operandB == '0) begin
                     data_result    <= '0;
                     data_remainder <= data_operandA;
                     data_exception <= 1'b1;
                     data_resultRDY <= 1'b1;
                     state          <= DONE;
                  end else begin
                     remReg <= '0;
                     quoReg <= magA;
                     cnt    <= '0;
                     busy   <= 1'b1;
                     state  <= RUN;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               remReg <= remNext;
               quoReg <= quoNext;
               if (cnt == CW'(WIDTH - 1)) begin
                  state <= FIX;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            FIX: begin
               data_result    <= negQ ? (~quoReg + 1'b1) : quoReg;
               data_remainder <= negR ? (~remReg + 1'b1) : remReg;
               data_exception <= 1'b0;
               data_resultRDY <= 1'b1;
               busy           <= 1'b0;
               state          <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq at WIDTH=32 and WIDTH=8 with hand-computed expectations.
// Inputs are driven just after falling edges; outputs are sampled on falling edges.
module tb_div_seq;

   logic        clock = 1'b0;
   logic        reset = 1'b1;

   logic        ctrlDiv = 1'b0;
   logic        ctrlSigned = 1'b0;
   logic [31:0] opA = '0;
   logic [31:0] opB = '0;
   logic [31:0] res;
   logic [31:0] rem;
   logic        exc;
   logic        rdy;
   logic        busy;

   logic        ctrlDiv8 = 1'b0;
   logic        ctrlSigned8 = 1'b0;
   logic [7:0]  opA8 = '0;
   logic [7:0]  opB8 = '0;
   logic [7:0]  res8;
   logic [7:0]  rem8;
   logic        exc8;
   logic        rdy8;
   logic        busy8;

   int nCompared = 0;
   int nMismatched = 0;

   always #5 clock = ~clock;

   div_seq #(.WIDTH(32)) dut32 (
      .clock         (clock),
      .reset         (reset),
      .ctrl_DIV      (ctrlDiv),
      .ctrl_signed   (ctrlSigned),
      .data_operandA (opA),
      .data_operandB (opB),
      .data_result   (res),
      .data_remainder(rem),
      .data_exception(exc),
      .data_resultRDY(rdy),
      .busy          (busy)
   );

   div_seq #(.WIDTH(8)) dut8 (
      .clock         (clock),
      .reset         (reset),
      .ctrl_DIV      (ctrlDiv8),
      .ctrl_signed   (ctrlSigned8),
      .data_operandA (opA8),
      .data_operandB (opB8),
      .data_result   (res8),
      .data_remainder(rem8),
      .data_exception(exc8),
      .data_resultRDY(rdy8),
      .busy          (busy8)
   );

   // Call right after a falling edge; returns at the falling edge of the RDY cycle.
   // rdyAt is j for cycle k+j, or -1 if no RDY within the bound.
   task automatic runOp32(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int rdyAt, output int busyCycles);
      ctrlDiv = 1'b1; ctrlSigned = s; opA = a; opB = b;
      rdyAt = -1; busyCycles = 0;
      for (int j = 1; j <= 60 && rdyAt < 0; j++) begin
         @(negedge clock);
         if (j == 1) ctrlDiv = 1'b0;
         if (busy) busyCycles++;
         if (rdy) rdyAt = j;
      end
   endtask

   task automatic runOp8(input logic [7:0] a, input logic [7:0] b, input logic s,
                         output int rdyAt);
      ctrlDiv8 = 1'b1; ctrlSigned8 = s; opA8 = a; opB8 = b;
      rdyAt = -1;
      for (int j = 1; j <= 40 && rdyAt < 0; j++) begin
         @(negedge clock);
         if (j == 1) ctrlDiv8 = 1'b0;
         if (rdy8) rdyAt = j;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      nCompared++; if (res !== 32'd0) begin nMismatched++; $display("FAIL reset_result got %h want 0", res); end
      nCompared++; if (rem !== 32'd0) begin nMismatched++; $display("FAIL reset_remainder got %h want 0", rem); end
      nCompared++; if (exc !== 1'b0) begin nMismatched++; $display("FAIL reset_exception got %b want 0", exc); end
      nCompared++; if (rdy !== 1'b0) begin nMismatched++; $display("FAIL reset_rdy got %b want 0", rdy); end
      nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("FAIL reset_busy got %b want 0", busy); end
      nCompared++; if ({res8, rem8, exc8, rdy8, busy8} !== 19'd0) begin nMismatched++; $display("FAIL reset_w8 got %h want 0", {res8, rem8, exc8, rdy8, busy8}); end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_unsigned();
      int rdyAt, busyCycles;
      runOp32(32'd100, 32'd7, 1'b0, rdyAt, busyCycles);
      nCompared++; if (res !== 32'd14) begin nMismatched++; $display("FAIL u100_7_q got %0d want 14", res); end
      nCompared++; if (rem !== 32'd2) begin nMismatched++; $display("FAIL u100_7_r got %0d want 2", rem); end
      nCompared++; if (exc !== 1'b0) begin nMismatched++; $display("FAIL u100_7_exc got %b want 0", exc); end
      nCompared++; if (rdyAt !== 34) begin nMismatched++; $display("FAIL u100_7_latency got %0d want 34", rdyAt); end
      nCompared++; if (busyCycles !== 33) begin nMismatched++; $display("FAIL u100_7_busy_cycles got %0d want 33", busyCycles); end
      @(negedge clock);
      nCompared++; if (rdy !== 1'b0) begin nMismatched++; $display("FAIL u100_7_rdy_pulse got %b want 0", rdy); end
      repeat (3) @(negedge clock);
      nCompared++; if (res !== 32'd14 || rem !== 32'd2) begin nMismatched++; $display("FAIL u100_7_hold got %0d/%0d want 14/2", res, rem); end
   endtask

   task automatic test_signed();
      int rdyAt, busyCycles;
      runOp32(32'hFFFF_FF9C, 32'd7, 1'b1, rdyAt, busyCycles);
      nCompared++; if (res !== 32'hFFFF_FFF2) begin nMismatched++; $display("FAIL sm100_7_q got %h want fffffff2", res); end
      nCompared++; if (rem !== 32'hFFFF_FFFE) begin nMismatched++; $display("FAIL sm100_7_r got %h want fffffffe", rem); end
      @(negedge clock);
      runOp32(32'd100, 32'hFFFF_FFF9, 1'b1, rdyAt, busyCycles);
      nCompared++; if (res !== 32'hFFFF_FFF2) begin nMismatched++; $display("FAIL s100_m7_q got %h want fffffff2", res); end
      nCompared++; if (rem !== 32'd2) begin nMismatched++; $display("FAIL s100_m7_r got %h want 00000002", rem); end
      @(negedge clock);
      runOp32(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, rdyAt, busyCycles);
      nCompared++; if (res !== 32'd14) begin nMismatched++; $display("FAIL sm100_m7_q got %h want 0000000e", res); end
      nCompared++; if (rem !== 32'hFFFF_FFFE) begin nMismatched++; $display("FAIL sm100_m7_r got %h want fffffffe", rem); end
      nCompared++; if (rdyAt !== 34) begin nMismatched++; $display("FAIL signed_latency got %0d want 34", rdyAt); end
   endtask

   task automatic test_div_zero();
      int rdyAt, busyCycles;
      for (int m = 0; m < 2; m++) begin
         @(negedge clock);
         runOp32(32'd5, 32'd0, m[0], rdyAt, busyCycles);
         nCompared++; if (res !== 32'd0) begin nMismatched++; $display("FAIL dz%0d_q got %h want 0", m, res); end
         nCompared++; if (rem !== 32'd5) begin nMismatched++; $display("FAIL dz%0d_r got %h want 5", m, rem); end
         nCompared++; if (exc !== 1'b1) begin nMismatched++; $display("FAIL dz%0d_exc got %b want 1", m, exc); end
         nCompared++; if (rdyAt !== 1) begin nMismatched++; $display("FAIL dz%0d_latency got %0d want 1", m, rdyAt); end
         nCompared++; if (busyCycles !== 0) begin nMismatched++; $display("FAIL dz%0d_busy got %0d want 0", m, busyCycles); end
      end
   endtask

   task automatic test_overflow();
      int rdyAt, busyCycles;
      @(negedge clock);
      runOp32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, rdyAt, busyCycles);
      nCompared++; if (res !== 32'h8000_0000) begin nMismatched++; $display("FAIL ovf_q got %h want 80000000", res); end
      nCompared++; if (rem !== 32'd0) begin nMismatched++; $display("FAIL ovf_r got %h want 0", rem); end
      nCompared++; if (exc !== 1'b0) begin nMismatched++; $display("FAIL ovf_exc got %b want 0", exc); end
   endtask

   task automatic test_ignore_start();
      int rdyAt, extraRdy;
      @(negedge clock);
      ctrlDiv = 1'b1; ctrlSigned = 1'b0; opA = 32'd1000; opB = 32'd10;
      rdyAt = -1;
      for (int j = 1; j <= 60 && rdyAt < 0; j++) begin
         @(negedge clock);
         ctrlDiv = (j == 5);
         if (j == 5) begin opA = 32'd7; opB = 32'd1; end
         if (rdy) rdyAt = j;
      end
      ctrlDiv = 1'b0;
      nCompared++; if (rdyAt !== 34) begin nMismatched++; $display("FAIL ignore_latency got %0d want 34", rdyAt); end
      nCompared++; if (res !== 32'd100 || rem !== 32'd0) begin nMismatched++; $display("FAIL ignore_result got %0d/%0d want 100/0", res, rem); end
      extraRdy = 0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clock);
         if (rdy || busy) extraRdy++;
      end
      nCompared++; if (extraRdy !== 0) begin nMismatched++; $display("FAIL ignore_no_queue got %0d activity cycles want 0", extraRdy); end
   endtask

   task automatic test_back_to_back();
      int rdyAt, busyCycles;
      @(negedge clock);
      runOp32(32'd50, 32'd6, 1'b0, rdyAt, busyCycles);
      nCompared++; if (rdyAt !== 34 || res !== 32'd8 || rem !== 32'd2) begin nMismatched++; $display("FAIL b2b_first got rdy %0d q %0d r %0d want 34/8/2", rdyAt, res, rem); end
      runOp32(32'd77, 32'd5, 1'b0, rdyAt, busyCycles);
      nCompared++; if (rdyAt !== 34) begin nMismatched++; $display("FAIL b2b_latency got %0d want 34", rdyAt); end
      nCompared++; if (busyCycles !== 33) begin nMismatched++; $display("FAIL b2b_busy got %0d want 33", busyCycles); end
      nCompared++; if (res !== 32'd15 || rem !== 32'd2) begin nMismatched++; $display("FAIL b2b_second got %0d/%0d want 15/2", res, rem); end
   endtask

   task automatic test_reset_mid();
      int activity;
      @(negedge clock);
      ctrlDiv = 1'b1; ctrlSigned = 1'b0; opA = 32'd1000; opB = 32'd3;
      for (int j = 1; j <= 10; j++) begin
         @(negedge clock);
         if (j == 1) ctrlDiv = 1'b0;
      end
      nCompared++; if (busy !== 1'b1) begin nMismatched++; $display("FAIL midrst_busy_before got %b want 1", busy); end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      nCompared++; if (res !== 32'd0 || rem !== 32'd0 || exc !== 1'b0) begin nMismatched++; $display("FAIL midrst_outputs got %h/%h/%b want 0/0/0", res, rem, exc); end
      nCompared++; if (busy !== 1'b0 || rdy !== 1'b0) begin nMismatched++; $display("FAIL midrst_flags got busy %b rdy %b want 0/0", busy, rdy); end
      activity = 0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clock);
         if (rdy || busy) activity++;
      end
      nCompared++; if (activity !== 0) begin nMismatched++; $display("FAIL midrst_no_rdy got %0d activity cycles want 0", activity); end
   endtask

   task automatic test_width8();
      int rdyAt;
      @(negedge clock);
      runOp8(8'd255, 8'd16, 1'b0, rdyAt);
      nCompared++; if (res8 !== 8'd15 || rem8 !== 8'd15) begin nMismatched++; $display("FAIL w8_255_16 got %0d/%0d want 15/15", res8, rem8); end
      nCompared++; if (rdyAt !== 10) begin nMismatched++; $display("FAIL w8_latency got %0d want 10", rdyAt); end
      @(negedge clock);
      runOp8(8'h80, 8'd3, 1'b1, rdyAt);
      nCompared++; if (res8 !== 8'hD6) begin nMismatched++; $display("FAIL w8_m128_3_q got %h want d6", res8); end
      nCompared++; if (rem8 !== 8'hFE) begin nMismatched++; $display("FAIL w8_m128_3_r got %h want fe", rem8); end
      nCompared++; if (exc8 !== 1'b0) begin nMismatched++; $display("FAIL w8_exc got %b want 0", exc8); end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_overflow();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      test_width8();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
